// File: rtl/codeword_shift_reg.sv
// rtl/codeword_shift_reg.sv - parallel-load codeword register with counted serial shift-out
module codeword_shift_reg #(
    parameter int WIDTH  = 7,
    parameter bit ROTATE = 1'b0
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         EN,
    input  logic                         L,
    input  logic [WIDTH-1:0]             D,
    input  logic                         SH,
    input  logic                         DIR,
    input  logic                         SIN,
    output logic [WIDTH-1:0]             Q,
    output logic [WIDTH-1:0]             Q_bar,
    output logic                         SOUT,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [$clog2(WIDTH+1)-1:0]   CNT
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] q;
    logic [CW-1:0]   cnt;
    logic            dir_l;
    logic            dir_sel;
    logic            sout;
    logic            fill;
    logic [WIDTH-1:0] q_shifted;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            S_IDLE: begin
                if (EN && !L && SH) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                BUSY = 1'b1;
                if (EN && (cnt == CNT_LAST)) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                DONE = 1'b1;
                if (EN) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Idle previews the live DIR input; once shifting, the latched direction rules.
    assign dir_sel   = (state == S_IDLE) ? DIR : dir_l;
    assign sout      = dir_sel ? q[0] : q[WIDTH-1];
    assign fill      = ROTATE ? sout : SIN;
    assign q_shifted = dir_l ? {fill, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill};

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            q     <= '0;
            cnt   <= '0;
            dir_l <= 1'b0;
        end else if (EN) begin
            case (state)
                S_IDLE: begin
                    if (L) begin
                        q <= D;
                    end else if (SH) begin
                        cnt   <= '0;
                        dir_l <= DIR;
                    end
                end
                S_SHIFT: begin
                    q   <= q_shifted;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Q     = q;
    assign Q_bar = ~q;
    assign SOUT  = sout;
    assign CNT   = cnt;

endmodule

// File: doc/codeword_shift_reg.md
CODEWORD_SHIFT_REG -- requirements
Module: codeword_shift_reg

Interface
REQ-001 Parameter WIDTH, default 7, codeword width in bits; legal range 2..64.
REQ-002 Parameter ROTATE, default 0; 1 = outgoing bit recirculates into the vacated end and SIN is ignored.
REQ-003 CLK  input  1  clock; all state changes on the rising edge.
REQ-004 CLR  input  1  reset, asynchronous, active-high.
REQ-005 EN  input  1  clock enable; low = all state, counter and outputs frozen.
REQ-006 L  input  1  parallel load request.
REQ-007 D  input  WIDTH  parallel load data.
REQ-008 SH  input  1  start-serial-shift request.
REQ-009 DIR  input  1  shift direction, sampled at start: 0 = MSB out first, 1 = LSB out first.
REQ-010 SIN  input  1  serial input bit.
REQ-011 Q  output  WIDTH  register contents.
REQ-012 Q_bar  output  WIDTH  bitwise inverse of Q, always.
REQ-013 SOUT  output  1  current outgoing bit.
REQ-014 BUSY  output  1  high while in SHIFT.
REQ-015 DONE  output  1  one-cycle completion pulse.
REQ-016 CNT  output  clog2(WIDTH+1)  shifts completed in the current operation.

Function
REQ-017 The FSM SHALL have states IDLE, SHIFT and FIN, with all transitions qualified by EN=1 at the clock edge.
REQ-018 In IDLE with EN=1 and L=1, Q SHALL take D on that edge and the state SHALL remain IDLE.
REQ-019 In IDLE with EN=1, L=0 and SH=1, the state SHALL go to SHIFT, CNT SHALL clear to 0, DIR SHALL be latched, and Q SHALL not move on that edge.
REQ-020 If L and SH are both high in IDLE, load SHALL win and SH SHALL be ignored for that cycle.
REQ-021 In SHIFT, each EN=1 edge SHALL perform one shift and increment CNT.
REQ-022 DIR latched 0: Q <= {Q[WIDTH-2:0], in}; SOUT = Q[WIDTH-1].
REQ-023 DIR latched 1: Q <= {in, Q[WIDTH-1:1]}; SOUT = Q[0].
REQ-024 The fill bit "in" SHALL be SIN when ROTATE=0, and SOUT when ROTATE=1.
REQ-025 The edge performing shift number WIDTH SHALL move the state to FIN, with CNT = WIDTH.
REQ-026 SOUT SHALL therefore present exactly WIDTH valid bits, one per enabled SHIFT cycle.
REQ-027 In FIN, DONE SHALL be 1 for that cycle, and the next EN=1 edge SHALL return the state to IDLE with CNT unchanged.
REQ-028 In IDLE, SOUT SHALL follow the current DIR input over current Q.
REQ-029 L and SH SHALL be ignored in SHIFT and FIN (no reload, no restart).
REQ-030 EN=0 mid-SHIFT SHALL pause: Q, CNT, state and SOUT hold, and shifting resumes on the next EN=1 edge with the bit count preserved.
REQ-031 DONE is a state decode; if EN=0 in FIN, DONE SHALL stay high until FIN is exited.
REQ-032 BUSY SHALL be 1 exactly when state = SHIFT.
REQ-033 With ROTATE=1, Q after completion SHALL equal Q at start.

Reset
REQ-034 CLR=1 SHALL immediately force state IDLE, Q=0, Q_bar=all ones, CNT=0, BUSY=0 and DONE=0, independent of CLK and EN.
REQ-035 CLR asserted mid-SHIFT SHALL abort the operation with no DONE pulse; SOUT SHALL read 0 after reset.
REQ-036 After CLR deasserts, the first rising edge SHALL operate normally from IDLE.

Verification (WIDTH=7 unless stated)
REQ-037 Load test: EN=1, L=1, D=7'b1011001 -> Q=1011001, Q_bar=0100110 after 1 edge; then SH, DIR=0, SIN=0 -> SOUT sequence 1,0,1,1,0,0,1 over 7 BUSY cycles, DONE on cycle 8, final Q=0.
REQ-038 ROTATE=1, DIR=1, Q=7'b0000011 -> SOUT sequence 1,1,0,0,0,0,0; Q=0000011 at DONE; CNT=7.
REQ-039 Pause: EN=0 for 3 cycles after shift 3 -> CNT holds 3 and SOUT holds; the total of 7 bits is unchanged and DONE arrives 3 cycles late.
REQ-040 Collision: L=1 and SH=1 together in IDLE -> load only, BUSY stays 0; L pulse during SHIFT -> Q is not reloaded.
REQ-041 CLR asynchronous mid-SHIFT at CNT=4, asserted between edges -> Q=0 and BUSY=0 immediately, no DONE; a fresh SH then shifts 7 bits.
REQ-042 WIDTH=16 regression: load 16'hA5C3 with DIR=1 -> SOUT is bits 0..15 of A5C3 in order, DONE after 16 shifts.
